// File: rtl/rv_serial_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | rv_serial_receiver
// | Framed serial-to-parallel deserializer with a one-entry valid/ready output.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module rv_serial_receiver #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_data,
  input  logic             frame_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             framing_error,
  output logic             overrun,
  input  logic             clear_overrun
);

  localparam int              C_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic               framing_error_q, framing_error_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               overrun_q, overrun_d;

  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_first;
  logic               w_word_done;
  logic               w_drop;

  if (WIDTH < 2) begin : g_width_check
    $error("rv_serial_receiver: WIDTH must be >= 2");
  end

  // w_first is the shift of an all-zero register, so a fresh word starts
  // exactly where the bit order expects its first bit to travel from.
  if (MSB_FIRST) begin : g_msb_first
    assign w_shifted = (sr_q << 1) | WIDTH'(bit_data);
    assign w_first   = WIDTH'(bit_data);
  end else begin : g_lsb_first
    assign w_shifted = (sr_q >> 1) | {bit_data, {(WIDTH-1){1'b0}}};
    assign w_first   = {bit_data, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      sr_q            <= '0;
      framing_error_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      sr_q            <= sr_d;
      framing_error_q <= framing_error_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      overrun_q       <= overrun_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    sr_d            = sr_q;
    framing_error_d = 1'b0;
    w_word_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_valid && frame_start) begin
          sr_d    = w_first;
          count_d = C_CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (frame_start) begin
            // A restart mid-word wins over completion, even on the last bit.
            framing_error_d = 1'b1;
            sr_d            = w_first;
            count_d         = C_CNT_W'(1);
          end else if (count_q == C_LAST_CNT) begin
            w_word_done = 1'b1;
            sr_d        = '0;
            count_d     = '0;
            state_d     = IDLE;
          end else begin
            sr_d    = w_shifted;
            count_d = count_q + C_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign w_drop = w_word_done && out_valid_q && !out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_word_done && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_data_d  = w_shifted;
    end
    if (w_drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_serial_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_rv_serial_receiver
// | Directed bench: MSB-first and LSB-first instances checked against a bit-list model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_rv_serial_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       frame_start = 1'b0;
  logic       out_ready = 1'b1;
  logic       clear_overrun = 1'b0;

  logic       m_valid, l_valid, m_ferr, l_ferr, m_ovr, l_ovr;
  logic [7:0] m_data, l_data;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  rv_serial_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_data(bit_data),
    .frame_start(frame_start), .out_valid(m_valid), .out_ready(out_ready),
    .out_data(m_data), .framing_error(m_ferr), .overrun(m_ovr),
    .clear_overrun(clear_overrun)
  );

  rv_serial_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_data(bit_data),
    .frame_start(frame_start), .out_valid(l_valid), .out_ready(out_ready),
    .out_data(l_data), .framing_error(l_ferr), .overrun(l_ovr),
    .clear_overrun(clear_overrun)
  );

  // Model: the frame is kept as a list of received bits; a finished list is
  // turned into a word by placing bit i at position 7-i (MSB first) or i.
  bit       md_in_word = 1'b0;
  int       md_nbits = 0;
  bit       md_bits[8];
  bit       md_valid = 1'b0;
  bit [7:0] md_word_m = 8'h00;
  bit [7:0] md_word_l = 8'h00;
  bit       md_ferr = 1'b0;
  bit       md_ovr = 1'b0;

  always @(posedge clk) begin
    bit done, ferr_n, old_v;
    if (rst) begin
      md_in_word = 1'b0; md_nbits = 0; md_valid = 1'b0;
      md_word_m = 8'h00; md_word_l = 8'h00; md_ferr = 1'b0; md_ovr = 1'b0;
    end else begin
      done = 1'b0; ferr_n = 1'b0; old_v = md_valid;
      if (bit_valid) begin
        if (frame_start) begin
          ferr_n = md_in_word;
          md_bits[0] = bit_data; md_nbits = 1; md_in_word = 1'b1;
        end else if (md_in_word) begin
          md_bits[md_nbits] = bit_data;
          md_nbits++;
          if (md_nbits == 8) begin
            done = 1'b1; md_in_word = 1'b0; md_nbits = 0;
          end
        end
      end
      if (old_v && out_ready) md_valid = 1'b0;
      if (done && (!old_v || out_ready)) begin
        md_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
          md_word_m[7-i] = md_bits[i];
          md_word_l[i]   = md_bits[i];
        end
      end
      if (done && old_v && !out_ready) md_ovr = 1'b1;
      else if (clear_overrun) md_ovr = 1'b0;
      md_ferr = ferr_n;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      #1;
      check("m_valid", 32'(m_valid), 32'(md_valid));
      check("l_valid", 32'(l_valid), 32'(md_valid));
      if (md_valid) begin
        check("m_data", 32'(m_data), 32'(md_word_m));
        check("l_data", 32'(l_data), 32'(md_word_l));
      end
      check("m_ferr", 32'(m_ferr), 32'(md_ferr));
      check("l_ferr", 32'(l_ferr), 32'(md_ferr));
      check("m_ovr", 32'(m_ovr), 32'(md_ovr));
      check("l_ovr", 32'(l_ovr), 32'(md_ovr));
    end
  end

  task automatic drive(input logic bv, input logic bd, input logic fs);
    @(negedge clk);
    bit_valid = bv; bit_data = bd; frame_start = fs;
  endtask

  // Stream order is w[7] first; rdy_last raises out_ready only with the last bit.
  task automatic send_word(input logic [7:0] w, input int gap, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, w[7-i], i == 0);
      if (i == 7 && rdy_last) out_ready = 1'b1;
      if (i < 7) repeat (gap) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", 32'(m_valid), 32'h0);
    check("reset_data", 32'(m_data), 32'h0);
    check("reset_ovr", 32'(m_ovr), 32'h0);
    cmp_en = 1'b1;

    // Plain word, out_ready high: one-cycle valid pulse.
    send_word(8'hA5, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t1_valid", 32'(m_valid), 32'h1);
    check("t1_data_m", 32'(m_data), 32'hA5);
    check("t1_data_l", 32'(l_data), 32'hA5);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t1_valid_drop", 32'(m_valid), 32'h0);

    // Stray bits in IDLE, then a gapped word.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t2_stray_valid", 32'(m_valid), 32'h0);
    send_word(8'hA5, 3, 1'b0);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t2_data", 32'(m_data), 32'hA5);

    // Back-to-back words into a stalled output: second is dropped.
    @(negedge clk); out_ready = 1'b0; bit_valid = 1'b0;
    send_word(8'h3C, 0, 1'b0);
    send_word(8'hC3, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t3_data_m", 32'(m_data), 32'h3C);
    check("t3_data_l", 32'(l_data), 32'h3C);
    check("t3_ovr", 32'(m_ovr), 32'h1);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; #1;
    check("t3_drained", 32'(m_valid), 32'h0);
    check("t3_ovr_sticky", 32'(m_ovr), 32'h1);
    @(negedge clk); clear_overrun = 1'b1;
    @(negedge clk); clear_overrun = 1'b0; #1;
    check("t3_ovr_clr", 32'(m_ovr), 32'h0);

    // Drain and refill on the same edge.
    send_word(8'h11, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t4_hold", 32'(m_data), 32'h11);
    send_word(8'h22, 0, 1'b1);
    @(negedge clk); bit_valid = 1'b0; out_ready = 1'b0; #1;
    check("t4_valid", 32'(m_valid), 32'h1);
    check("t4_data_m", 32'(m_data), 32'h22);
    check("t4_data_l", 32'(l_data), 32'h44);
    check("t4_no_ovr", 32'(m_ovr), 32'h0);
    @(negedge clk); out_ready = 1'b1;

    // Restart on bit 5, then 0xF0.
    drive(1'b1, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0); #1;
    check("t5_ferr", 32'(m_ferr), 32'h1);
    drive(1'b1, 1'b1, 1'b0); #1;
    check("t5_ferr_pulse", 32'(m_ferr), 32'h0);
    drive(1'b1, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t5_data_m", 32'(m_data), 32'hF0);
    check("t5_data_l", 32'(l_data), 32'h0F);

    // Restart on the 8th bit of a frame: nothing emitted, new word follows.
    drive(1'b1, 1'b1, 1'b1);
    repeat (6) drive(1'b1, 1'b1, 1'b0);
    send_word(8'h5A, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t6_data", 32'(m_data), 32'h5A);

    // Reset with a held word and a partial word in flight.
    @(negedge clk); out_ready = 1'b0;
    send_word(8'hA5, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    @(negedge clk); bit_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
    check("t7_rst_valid", 32'(m_valid), 32'h0);
    check("t7_rst_data", 32'(l_data), 32'h0);
    check("t7_rst_ferr", 32'(m_ferr), 32'h0);
    send_word(8'h81, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); #1;
    check("t7_data_m", 32'(m_data), 32'h81);
    check("t7_data_l", 32'(l_data), 32'h81);

    repeat (3) drive(1'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
